// File: rtl/bus_uart_tx.sv
// bus_uart_tx
// Memory-mapped 8N1 UART transmitter on the core data bus. Software pushes
// bytes into a small TX FIFO through a 16-byte register window. A baud-rate
// state machine serialises the bytes onto a registered TX pin.
//
// Ports:
//   iwClk        single clock; all state updates on its rising edge
//   iwRst        synchronous, active-high reset
//   iwReadAddr   bus read address, decoded every cycle
//   iwWriteAddr  bus write address
//   iwWriteData  bus write data
//   iwWstrb      byte write strobes; all-zero means no write this cycle
//   owReadData   registered read data, one cycle after iwReadAddr
//   owTx         UART serial output, idle high
//
// Register window (word offset addr[3:2]):
//   0x0 TXDATA   write byte lane 0 pushes a byte; reads 0
//   0x4 STATUS   {16'b0, level[7:0], 4'b0, OVERFLOW, BUSY, EMPTY, FULL}
//                writing lane 0 with bit3 set clears OVERFLOW
//   0x8 DIVISOR  clocks per bit, lanes 0/1 writable
//   0xC          reserved; reads 0, writes ignored
module bus_uart_tx #(
  parameter logic [31:0] pBaseAddr       = 32'hF000_0000,
  parameter logic [15:0] pDefaultDivisor = 16'd217,
  parameter int          pFifoDepthLog2  = 3
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwReadAddr,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  output logic [31:0] owReadData,
  output logic        owTx
);

  localparam int cDepth = 1 << pFifoDepthLog2;
  localparam int cLvlW  = pFifoDepthLog2 + 1;
  localparam logic [pFifoDepthLog2-1:0] cPtrOne  = 1;
  localparam logic [cLvlW-1:0]          cLvlOne  = 1;
  localparam logic [cLvlW-1:0]          cLvlFull = cLvlW'(cDepth);

  typedef enum logic [1:0] {
    sIdle,
    sStart,
    sData,
    sStop
  } tState;

  // FIFO storage and bookkeeping
  logic [7:0]                fifoMem [cDepth];
  logic [pFifoDepthLog2-1:0] wrPtrReg;
  logic [pFifoDepthLog2-1:0] rdPtrReg;
  logic [cLvlW-1:0]          levelReg;
  logic                      overflowReg;
  logic [15:0]               divisorReg;

  // Transmit state machine
  tState       stateReg;
  logic [15:0] baudCntReg;
  logic [2:0]  bitIdxReg;
  logic [7:0]  shiftReg;
  logic        txReg;
  logic [31:0] readDataReg;

  // Bus decode
  logic        wrInWindow;
  logic        rdInWindow;
  logic        wrTxData;
  logic        wrOvfClear;
  logic        wrDivLo;
  logic        wrDivHi;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        busy;
  logic        bitDone;
  logic        pop;
  logic        pushOk;
  logic        pushDrop;
  logic [15:0] effDiv;
  logic [31:0] readMux;
  logic        unusedBits;

  assign wrInWindow = (iwWriteAddr[31:4] == pBaseAddr[31:4]);
  assign rdInWindow = (iwReadAddr[31:4] == pBaseAddr[31:4]);

  assign wrTxData   = wrInWindow && (iwWriteAddr[3:2] == 2'd0) && iwWstrb[0];
  assign wrOvfClear = wrInWindow && (iwWriteAddr[3:2] == 2'd1) && iwWstrb[0] && iwWriteData[3];
  assign wrDivLo    = wrInWindow && (iwWriteAddr[3:2] == 2'd2) && iwWstrb[0];
  assign wrDivHi    = wrInWindow && (iwWriteAddr[3:2] == 2'd2) && iwWstrb[1];

  assign fifoFull  = (levelReg == cLvlFull);
  assign fifoEmpty = (levelReg == '0);
  assign busy      = (stateReg != sIdle);

  // A zero divisor behaves as one clock per bit.
  assign effDiv  = (divisorReg == 16'd0) ? 16'd1 : divisorReg;
  assign bitDone = (baudCntReg == 16'd1);

  // The FSM pops when idle, or at the very end of a stop bit so the next
  // start bit follows without an idle gap.
  assign pop = !fifoEmpty &&
               ((stateReg == sIdle) || ((stateReg == sStop) && bitDone));

  // A same-cycle pop frees a slot for the push even when full.
  assign pushOk   = wrTxData && (!fifoFull || pop);
  assign pushDrop = wrTxData && fifoFull && !pop;

  assign unusedBits = ^{iwReadAddr[1:0], iwWriteAddr[1:0],
                        iwWriteData[31:16], iwWstrb[3:2]};

  // FIFO storage is written without reset so it maps onto RAM.
  always_ff @(posedge iwClk) begin
    if (pushOk) begin
      fifoMem[wrPtrReg] <= iwWriteData[7:0];
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      levelReg <= '0;
    end else begin
      if (pushOk) begin
        wrPtrReg <= wrPtrReg + cPtrOne;
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + cPtrOne;
      end
      if (pushOk && !pop) begin
        levelReg <= levelReg + cLvlOne;
      end else if (pop && !pushOk) begin
        levelReg <= levelReg - cLvlOne;
      end
    end
  end

  // OVERFLOW is sticky; a drop in the same cycle as a clear wins.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      overflowReg <= 1'b0;
    end else if (pushDrop) begin
      overflowReg <= 1'b1;
    end else if (wrOvfClear) begin
      overflowReg <= 1'b0;
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      divisorReg <= pDefaultDivisor;
    end else begin
      if (wrDivLo) begin
        divisorReg[7:0] <= iwWriteData[7:0];
      end
      if (wrDivHi) begin
        divisorReg[15:8] <= iwWriteData[15:8];
      end
    end
  end

  // txReg follows the current state, so the pin lags the state by one
  // cycle uniformly; every bit still lasts exactly effDiv clocks.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      stateReg   <= sIdle;
      baudCntReg <= 16'd0;
      bitIdxReg  <= 3'd0;
      shiftReg   <= 8'd0;
      txReg      <= 1'b1;
    end else begin
      case (stateReg)
        sIdle: begin
          txReg <= 1'b1;
          if (pop) begin
            shiftReg   <= fifoMem[rdPtrReg];
            baudCntReg <= effDiv;
            stateReg   <= sStart;
          end
        end
        sStart: begin
          txReg <= 1'b0;
          if (bitDone) begin
            bitIdxReg  <= 3'd0;
            baudCntReg <= effDiv;
            stateReg   <= sData;
          end else begin
            baudCntReg <= baudCntReg - 16'd1;
          end
        end
        sData: begin
          txReg <= shiftReg[0];
          if (bitDone) begin
            baudCntReg <= effDiv;
            shiftReg   <= {1'b0, shiftReg[7:1]};
            if (bitIdxReg == 3'd7) begin
              stateReg <= sStop;
            end else begin
              bitIdxReg <= bitIdxReg + 3'd1;
            end
          end else begin
            baudCntReg <= baudCntReg - 16'd1;
          end
        end
        sStop: begin
          txReg <= 1'b1;
          if (bitDone) begin
            if (pop) begin
              shiftReg   <= fifoMem[rdPtrReg];
              baudCntReg <= effDiv;
              stateReg   <= sStart;
            end else begin
              baudCntReg <= 16'd0;
              stateReg   <= sIdle;
            end
          end else begin
            baudCntReg <= baudCntReg - 16'd1;
          end
        end
        default: begin
          txReg    <= 1'b1;
          stateReg <= sIdle;
        end
      endcase
    end
  end

  // Reads see register state from before this edge, so a same-cycle write
  // to the addressed register returns the old value.
  always_comb begin
    readMux = 32'd0;
    if (rdInWindow) begin
      case (iwReadAddr[3:2])
        2'd1:    readMux = {16'd0, 8'(levelReg), 4'd0,
                            overflowReg, busy, fifoEmpty, fifoFull};
        2'd2:    readMux = {16'd0, divisorReg};
        default: readMux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      readDataReg <= 32'd0;
    end else begin
      readDataReg <= readMux;
    end
  end

  assign owReadData = readDataReg;
  assign owTx       = txReg;

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
Memory-mapped UART transmitter that responds on the CPU data bus, the same read/write address, write data and byte-strobe interface the core drives toward memory. Software writes bytes into a transmit FIFO. A baud-rate state machine serialises them as 8N1 frames on a single TX pin. The block sits beside the memory responder on the core's bus and gives the SoC a debug console.

Parameters:
pBaseAddr, 32'hF000_0000, base of the 16-byte register window; decode compares addr[31:4] against pBaseAddr[31:4].
pDefaultDivisor, 16'd217, reset value of DIVISOR in clocks per bit (25 MHz / 115200).
pFifoDepthLog2, 3, log2 of TX FIFO depth (default 8 entries).

Ports:
iwClk  input  1  single clock; all state updates on its rising edge
iwRst  input  1  synchronous, active-high reset
iwReadAddr  input  32  bus read address, presented every cycle
iwWriteAddr  input  32  bus write address
iwWriteData  input  32  bus write data
iwWstrb  input  4  byte write strobes; all-zero means no write this cycle
owReadData  output  32  registered read data for iwReadAddr
owTx  output  1  UART serial output, idle high

Behaviour:
- Reset (iwRst=1 at an edge): owTx=1, owReadData=0, FIFO empty, FSM IDLE, DIVISOR=pDefaultDivisor, OVERFLOW=0, baud and bit counters cleared. Reset mid-frame aborts the frame immediately. owTx is high the cycle after the reset edge.
- Register map, word offset addr[3:2]:
  - 0x0 TXDATA: write with iwWstrb[0]=1 pushes iwWriteData[7:0]. Reads return 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVERFLOW (sticky).
    - bits[15:8] FIFO level, zero-extended.
    - Writing iwWstrb[0]=1 with iwWriteData[3]=1 clears OVERFLOW (W1C).
  - 0x8 DIVISOR: bits[15:0] R/W. iwWstrb[0] updates [7:0]; iwWstrb[1] updates [15:8]. Upper strobes are ignored. Reads return {16'b0, DIVISOR}.
  - 0xC and any address outside the window: reads return 0, writes ignored.
- Read latency is 1 cycle. owReadData at edge N+1 reflects iwReadAddr at edge N and register state before edge N. If a read and a write hit the same register in the same cycle, the read returns the pre-write value.
- FIFO:
  - A push when FULL is dropped and OVERFLOW is set.
  - A push and a pop in the same cycle when FULL: the pop happens first, so the push succeeds and the level is unchanged.
  - Push into empty FIFO while IDLE: the byte is visible to the FSM next cycle.
  - Pointers wrap modulo depth; level uses pFifoDepthLog2+1 bits.
- Baud: an effective divisor D = max(DIVISOR,1) is loaded into the baud counter at the start of every bit. Each bit lasts exactly D clocks. A DIVISOR write mid-frame takes effect at the next bit boundary.
- FSM:
  - IDLE: owTx=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: owTx=0 for D clocks, then DATA with bit index 0.
  - DATA: owTx=shift[0], LSB first, D clocks per bit. After bit 7, go to STOP.
  - STOP: owTx=1 for D clocks. At the end, if FIFO non-empty, pop and go directly to START (back-to-back, no extra idle bit); otherwise go to IDLE.
  - Frame length is exactly 10*D clocks.
- First start bit: owTx falls 2 cycles after the edge that accepted the write into an empty FIFO (push edge, pop edge, START output registered).
- owTx is driven from a register (glitch-free).

Test Plan:
- Reset with no bus activity -> owTx=1; read STATUS returns 0x0000_0002; read DIVISOR returns 217.
- DIVISOR=4; write 0x55 to TXDATA -> start bit low 4 clocks beginning 2 cycles after the write, then 1,0,1,0,1,0,1,0 at 4 clocks each, stop high 4 clocks; BUSY=1 during the 40-clock frame.
- DIVISOR=2; write 9 bytes 0x00..0x08 back-to-back, with the first popped immediately so no overflow -> 9 contiguous frames with no idle gap; then 10 writes with FSM busy -> OVERFLOW=1, exactly 9 bytes sent; W1C write 0x8 to STATUS -> OVERFLOW=0.
- Write TXDATA with iwWstrb=4'b0010 -> no push, STATUS unchanged. Write DIVISOR 0x1234 with iwWstrb=4'b0001 from 0x00D9 -> readback 0x0034.
- DIVISOR=0 -> each bit lasts 1 clock, frame is 10 clocks.
- Assert iwRst during DATA bit 3 -> owTx=1 next cycle, FIFO empty, no further transitions. Read 0xF000_000C and 0x0000_0000 -> 0.
